// File: rtl/uart_tx_fifo_if.sv
// Store-side bus of the buffered UART transmitter: write strobe plus FIFO status.
// tx_valid is a one-cycle strobe with no ready; the byte is taken only when fifo_full was 0 before the edge.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                    tx_data;
  logic                          tx_valid;
  logic                          busy;
  logic                          fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;

  modport master (
    output tx_data, tx_valid,
    input  busy, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  tx_data, tx_valid,
    output busy, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: circular FIFO feeding a start/data/stop serialiser.
// Strobes arriving while the FIFO is full are dropped and latch a sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_fifo_if.slave     bus,
  output logic              tx,
  output logic [1:0]        dbg_state
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = AW + 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CNT_W-1:0] OCC_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shift, shift_next;
  logic              tx_next;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              full, ovf;
  logic              push, pop, drop;

  // Full is judged on the registered flag, so a pop on the same edge never rescues a strobe.
  assign push = bus.tx_valid & ~full;
  assign drop = bus.tx_valid & full;
  assign pop  = (state == IDLE) && (count != '0);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + OCC_ONE;
    else if (pop && !push) count_next = count - OCC_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == OCC_MAX);
      if (drop) ovf <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next = START;
          cnt_next   = CNT_MAX;
          shift_next = mem[rd_ptr];
        end
      end
      START: begin
        if (cnt == '0) begin
          state_next = DATA;
          cnt_next   = CNT_MAX;
          bit_next   = 3'd0;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_next = {1'b0, shift[7:1]};
          cnt_next   = CNT_MAX;
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CNT_ONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The line is registered from the next state so it moves on the same edge as the FSM.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      tx      <= tx_next;
    end
  end

  assign bus.busy       = (state != IDLE) || (count != '0);
  assign bus.fifo_full  = full;
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf;
  assign dbg_state      = state;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a time-based queue model predicts accepted bytes and
// start-bit times; an independent serial receiver pops and compares every frame on the line.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int HALF  = 5;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx;
  logic [1:0] dbg_state;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .dbg_state(dbg_state)
  );

  always #HALF clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes waiting in the FIFO, cycles left in the current frame, sticky drop flag.
  logic [7:0] exp_q[$];
  int         exp_t_q[$];
  logic [7:0] mq[$];
  int         rem = 0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    exp_t_q.delete();
    rem   = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    bit full_pre, pop_pre;
    if (!rst) begin
      model_clear();
      return;
    end
    full_pre = (mq.size() == DEPTH);
    pop_pre  = (rem == 0) && (mq.size() != 0);
    if (pop_pre) begin
      exp_q.push_back(mq.pop_front());
      exp_t_q.push_back(int'($time));
      rem = FRAME;
    end else if (rem > 0) begin
      rem--;
    end
    if (v && !full_pre) mq.push_back(d);
    else if (v)         m_ovf = 1'b1;
  endtask

  task automatic check_flags();
    chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
    chk("fifo_full", 32'(bus.fifo_full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("busy", 32'(bus.busy), 32'((rem != 0) || (mq.size() != 0)));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    bus.tx_valid = v;
    bus.tx_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    bus.tx_valid = 1'b0;
    check_flags();
  endtask

  // Serial receiver, sampling mid-bit on the falling clock edge.
  logic       rx_act = 1'b0;
  int         rx_e = 0;
  logic [7:0] rx_byte = 8'd0;
  logic [7:0] rx_exp = 8'd0;
  logic       tx_prev = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      rx_act  = 1'b0;
      tx_prev = 1'b1;
    end else begin
      if (rx_act) begin
        rx_e++;
        if (rx_e == 2) begin
          chk("start_bit", 32'(tx), 32'(0));
        end else if (rx_e >= 6 && rx_e <= 34 && ((rx_e - 2) % 4) == 0) begin
          rx_byte[(rx_e - 6) / 4] = tx;
        end else if (rx_e == 38) begin
          chk("stop_bit", 32'(tx), 32'(1));
          chk("rx_byte", 32'(rx_byte), 32'(rx_exp));
          rx_act = 1'b0;
        end
      end else if (tx_prev && !tx) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got start bit expected idle line at %0t", $time);
        end else begin
          rx_exp = exp_q.pop_front();
          chk("start_time", 32'($time - HALF), 32'(exp_t_q.pop_front()));
          rx_act = 1'b1;
          rx_e   = 0;
        end
      end
      tx_prev = tx;
    end
  end

  task automatic drain();
    int n = 0;
    while ((rem != 0 || mq.size() != 0 || rx_act || exp_q.size() != 0) && n < 3000) begin
      step(1'b0, 8'd0);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
    repeat (3) step(1'b0, 8'd0);
  endtask

  task automatic wait_pop_edge();
    int n = 0;
    while (!(rem == 0 && mq.size() != 0) && n < 200) begin
      step(1'b0, 8'd0);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL pop_edge_timeout: got no pop edge expected one within %0d cycles", n);
    end
  endtask

  initial begin
    int k;
    int sent;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'd0;

    // Reset
    repeat (3) step(1'b0, 8'd0);
    chk("reset_tx", 32'(tx), 32'(1));
    chk("reset_busy", 32'(bus.busy), 32'(0));
    chk("reset_count", 32'(bus.fifo_count), 32'(0));
    rst = 1'b1;
    repeat (4) step(1'b0, 8'd0);

    // Single byte 0xA5: start bit on the following edge, busy falls 41 edges after the strobe
    step(1'b1, 8'hA5);
    step(1'b0, 8'd0);
    chk("single_tx_low", 32'(tx), 32'(0));
    k = 1;
    while (bus.busy && k < 200) begin
      step(1'b0, 8'd0);
      k++;
    end
    chk("single_busy_fall", 32'(k), 32'(41));
    drain();

    // Burst of ten: nine accepted, the tenth dropped
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i));
    chk("burst_count", 32'(bus.fifo_count), 32'(8));
    chk("burst_full", 32'(bus.fifo_full), 32'(1));
    chk("burst_overflow", 32'(bus.overflow), 32'(1));

    // Strobe on the pop edge while full is still dropped
    wait_pop_edge();
    step(1'b1, 8'h55);
    chk("popfull_count", 32'(bus.fifo_count), 32'(7));
    chk("popfull_overflow", 32'(bus.overflow), 32'(1));
    drain();

    // Simultaneous push and pop with two bytes waiting
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom_range(0, 255)));
    wait_pop_edge();
    chk("simul_pre_count", 32'(bus.fifo_count), 32'(2));
    step(1'b1, 8'($urandom_range(0, 255)));
    chk("simul_post_count", 32'(bus.fifo_count), 32'(2));
    drain();

    // Wrap-around: twenty bytes in groups of three
    sent = 0;
    while (sent < 20) begin
      for (int j = 0; j < 3 && sent < 20; j++) begin
        step(1'b1, 8'($urandom_range(0, 255)));
        sent++;
      end
      drain();
    end

    // Random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 5) == 0, 8'($urandom_range(0, 255)));
    drain();

    // Reset during data bit 3: the line rises with no clock edge
    step(1'b1, 8'h3C);
    repeat (19) step(1'b0, 8'd0);
    chk("mid_tx_low_data", 32'(dbg_state), 32'(2));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_reset_tx", 32'(tx), 32'(1));
    chk("mid_reset_busy", 32'(bus.busy), 32'(0));
    chk("mid_reset_count", 32'(bus.fifo_count), 32'(0));
    chk("mid_reset_full", 32'(bus.fifo_full), 32'(0));
    chk("mid_reset_overflow", 32'(bus.overflow), 32'(0));
    model_clear();
    repeat (2) step(1'b0, 8'd0);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'd0);
      chk("post_reset_idle_tx", 32'(tx), 32'(1));
    end

    chk("exp_q_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
